// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator: turns queued commands into classic single or wrapped-burst
// bus cycles, draining a show-ahead write FIFO and filling a read FIFO.
module wb_burst_master #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [1:0]      cmd_bte,
  input  logic [DW-1:0]   wr_data,
  input  logic            wr_empty,
  output logic            wr_re,
  output logic [DW-1:0]   rd_data,
  output logic            rd_we,
  input  logic            rd_full,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output logic            busy,
  output logic            err_o
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_we, w_we_nxt;
  logic [AW-1:0] r_adr, w_adr_nxt;
  logic [1:0]    r_bte, w_bte_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;

  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_adr_inc;
  logic          w_stb;
  logic          w_beat;

  // Wrap mask: only the low log2(N) address bits advance within a burst.
  always_comb begin
    w_mask = '0;
    case (r_bte)
      2'b01:   w_mask[1:0] = '1;
      2'b10:   w_mask[2:0] = '1;
      2'b11:   w_mask[3:0] = '1;
      default: w_mask      = '0;
    endcase
  end

  assign w_adr_inc = (r_adr & ~w_mask) | ((r_adr + AW'(1)) & w_mask);

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_adr_nxt   = r_adr;
    w_bte_nxt   = r_bte;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    cmd_ready   = 1'b0;
    wb_cyc_o    = 1'b0;
    w_stb       = 1'b0;
    wb_we_o     = 1'b0;
    wb_cti_o    = '0;
    wb_bte_o    = '0;
    case (r_state)
      IDLE: begin
        cmd_ready = wb_rst;
        if (cmd_valid) begin
          w_state_nxt = BUS;
          w_we_nxt    = cmd_we;
          w_adr_nxt   = cmd_adr;
          w_bte_nxt   = cmd_bte;
          case (cmd_bte)
            2'b01:   w_cnt_nxt = 4'd3;
            2'b10:   w_cnt_nxt = 4'd7;
            2'b11:   w_cnt_nxt = 4'd15;
            default: w_cnt_nxt = 4'd0;
          endcase
        end
      end
      BUS: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = r_we;
        w_stb    = r_we ? !wr_empty : !rd_full;
        if (r_bte != 2'b00) begin
          wb_bte_o = r_bte;
          wb_cti_o = (r_cnt == 4'd0) ? 3'b111 : 3'b010;
        end
        // Error takes priority over a simultaneous ack and abandons remaining beats.
        if (w_stb && wb_err_i) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_stb && wb_ack_i) begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
            w_adr_nxt = w_adr_inc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_bte   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_adr   <= w_adr_nxt;
      r_bte   <= w_bte_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign w_beat   = w_stb & wb_ack_i & !wb_err_i;
  assign wr_re    = w_beat & r_we;
  assign rd_we    = w_beat & !r_we;
  assign wb_stb_o = w_stb;
  assign wb_sel_o = {(DW/8){wb_cyc_o}};
  assign wb_adr_o = r_adr;
  assign wb_dat_o = wr_data;
  assign rd_data  = wb_dat_i;
  assign busy     = wb_cyc_o;
  assign err_o    = r_err;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a scoreboard of expected beats is filled when a
// command is issued and drained as the bus model acknowledges strobed beats.
module tb_wb_burst_master;
  localparam int AW = 30;
  localparam int DW = 32;

  logic            wb_clk = 1'b0;
  logic            wb_rst;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_adr;
  logic [1:0]      cmd_bte;
  logic [DW-1:0]   wr_data;
  logic            wr_empty, wr_re;
  logic [DW-1:0]   rd_data;
  logic            rd_we, rd_full;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i, wb_err_i;
  logic            busy, err_o;

  wb_burst_master #(.AW(AW), .DW(DW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_bte(cmd_bte),
    .wr_data(wr_data), .wr_empty(wr_empty), .wr_re(wr_re),
    .rd_data(rd_data), .rd_we(rd_we), .rd_full(rd_full),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy(busy), .err_o(err_o)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [AW-1:0] adr;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          we;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         sbq[$];
  logic [DW-1:0] wq[$];
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " cyc"}, wb_cyc_o, 0);
    chk({tag, " stb"}, wb_stb_o, 0);
    chk({tag, " we"}, wb_we_o, 0);
    chk({tag, " adr"}, wb_adr_o, 0);
    chk({tag, " cti"}, wb_cti_o, 0);
    chk({tag, " bte"}, wb_bte_o, 0);
    chk({tag, " wr_re"}, wr_re, 0);
    chk({tag, " rd_we"}, rd_we, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " err_o"}, err_o, 0);
    chk({tag, " cmd_ready"}, cmd_ready, 0);
  endtask

  // Issues one command right away (caller is mid-cycle) and services the bus until it ends.
  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [1:0] bte,
                         input int ack_wait, input int thr_beat, input int thr_len,
                         input int err_beat, input bit err_ack, input int rst_beat,
                         input string tag);
    int n, done, left, c, wc, n_pops, exp_pops;
    bit pop, fin, aborted, hit_rst, thr, ack_now, err_now;
    n = (bte == 2'b00) ? 1 : (2 << bte);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.adr  = AW'((adr / AW'(n)) * AW'(n) + ((adr % AW'(n)) + AW'(i)) % AW'(n));
      b.cti  = (bte == 2'b00) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      b.bte  = bte;
      b.we   = we;
      b.data = $urandom();
      sbq.push_back(b);
      if (we) wq.push_back(b.data);
    end
    exp_pops = (err_beat >= 0) ? err_beat : n;
    wr_empty  = (wq.size() == 0);
    wr_data   = (wq.size() != 0) ? wq[0] : '0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_bte   = bte;
    #1;
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    done = 0; left = thr_len; c = 0; wc = 0; n_pops = 0;
    pop = 0; fin = 0; aborted = 0; hit_rst = 0;
    while (!fin) begin
      @(negedge wb_clk);
      c++;
      cmd_valid = 1'b0;
      if (pop) void'(wq.pop_front());
      pop = 0;
      if (c > 100) begin
        chk({tag, " timeout cyc"}, wb_cyc_o, 0);
        sbq.delete();
        break;
      end
      if (rst_beat == done) begin
        wb_rst = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; rd_full = 1'b0;
        hit_rst = 1;
        break;
      end
      thr = (done == thr_beat) && (left > 0);
      if (thr) left--;
      rd_full  = !we && thr;
      wr_empty = (wq.size() == 0) || (we && thr);
      wr_data  = (wq.size() != 0) ? wq[0] : '0;
      wb_dat_i = sbq[0].data;
      wb_ack_i = thr;  // stray ack while strobe is low must be ignored
      wb_err_i = 1'b0;
      #1;
      if (c == 1) chk({tag, " cyc at T+1"}, wb_cyc_o, 1);
      if (!wb_cyc_o) begin
        chk({tag, " early cyc drop"}, wb_cyc_o, 1);
        sbq.delete();
        break;
      end
      chk({tag, " busy"}, busy, 1);
      chk({tag, " adr"}, wb_adr_o, sbq[0].adr);
      chk({tag, " cti"}, wb_cti_o, sbq[0].cti);
      chk({tag, " bte"}, wb_bte_o, sbq[0].bte);
      chk({tag, " we"}, wb_we_o, sbq[0].we);
      chk({tag, " stb"}, wb_stb_o, !thr);
      if (wb_stb_o) begin
        chk({tag, " sel"}, wb_sel_o, 4'hF);
        ack_now  = (wc >= ack_wait);
        err_now  = ack_now && (done == err_beat);
        wb_ack_i = ack_now && (!err_now || err_ack);
        wb_err_i = err_now;
        #1;
        chk({tag, " wr_re"}, wr_re, we && ack_now && !err_now);
        chk({tag, " rd_we"}, rd_we, !we && ack_now && !err_now);
        if (wr_re || rd_we) n_pops++;
        if (err_now) begin
          aborted = 1;
          fin = 1;
        end else if (ack_now) begin
          if (we) chk({tag, " wb_dat_o"}, wb_dat_o, sbq[0].data);
          else    chk({tag, " rd_data"}, rd_data, sbq[0].data);
          pop = we;
          void'(sbq.pop_front());
          done++;
          wc = 0;
          if (sbq.size() == 0) fin = 1;
        end else begin
          wc++;
        end
      end else begin
        chk({tag, " stray wr_re"}, wr_re, 0);
        chk({tag, " stray rd_we"}, rd_we, 0);
      end
    end
    if (hit_rst) begin
      @(negedge wb_clk);
      #1;
      chk_zero({tag, " in reset"});
      sbq.delete();
      wq.delete();
      wb_rst = 1'b1;
      wr_empty = 1'b1;
      #1;
      chk({tag, " cmd_ready after release"}, cmd_ready, 1);
      @(negedge wb_clk);
      #1;
      chk({tag, " idle after release"}, wb_cyc_o, 0);
      return;
    end
    @(negedge wb_clk);
    if (pop) void'(wq.pop_front());
    wb_ack_i = 1'b0; wb_err_i = 1'b0; rd_full = 1'b0;
    if (aborted) begin
      sbq.delete();
      wq.delete();
    end
    wr_empty = (wq.size() == 0);
    wr_data  = (wq.size() != 0) ? wq[0] : '0;
    #1;
    chk({tag, " end cyc"}, wb_cyc_o, 0);
    chk({tag, " end stb"}, wb_stb_o, 0);
    chk({tag, " end busy"}, busy, 0);
    chk({tag, " end cmd_ready"}, cmd_ready, 1);
    chk({tag, " err_o"}, err_o, aborted);
    chk({tag, " fifo ops"}, n_pops, exp_pops);
    if (aborted) begin
      @(negedge wb_clk);
      #1;
      chk({tag, " err_o single pulse"}, err_o, 0);
    end
  endtask

  initial begin
    wb_rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_bte = '0;
    wr_data = '0; wr_empty = 1'b1; rd_full = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (3) @(negedge wb_clk);
    #1;
    chk_zero("reset hold");
    @(negedge wb_clk);
    wb_rst = 1'b1;
    #1;
    chk("cmd_ready after reset", cmd_ready, 1);
    chk("cyc after reset", wb_cyc_o, 0);

    //      we    adr       bte    wait thr_b thr_l err_b eack rst_b
    run_cmd(1'b0, 30'h10,  2'b00, 1,   -1,   0,    -1,   0,   -1,   "single_rd");
    run_cmd(1'b1, 30'h0D,  2'b10, 0,   -1,   0,    -1,   0,   -1,   "wrap8_wr");
    run_cmd(1'b0, 30'h06,  2'b01, 0,    2,   3,    -1,   0,   -1,   "wrap4_rd_full");
    run_cmd(1'b1, 30'h103, 2'b01, 0,    1,   2,    -1,   0,   -1,   "wrap4_wr_empty");
    run_cmd(1'b1, 30'h25,  2'b11, 0,   -1,   0,     4,   1,   -1,   "wrap16_wr_err");
    run_cmd(1'b0, 30'h41,  2'b01, 1,   -1,   0,     0,   0,   -1,   "wrap4_rd_err");
    run_cmd(1'b0, 30'h3A,  2'b10, 0,   -1,   0,    -1,   0,    2,   "wrap8_rd_rst");
    run_cmd(1'b1, 30'h77,  2'b00, 0,   -1,   0,    -1,   0,   -1,   "b2b_single_wr");
    run_cmd(1'b0, 30'h1F2, 2'b01, 0,   -1,   0,    -1,   0,   -1,   "b2b_wrap4_rd");
    run_cmd(1'b0, 30'h2C,  2'b11, 2,   -1,   0,    -1,   0,   -1,   "b2b_wrap16_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
